program_loader: RTL and testbench

//  Upstream feeder for the pipelined CPU's byte-wide program memory. Accepts a framed

---
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Feeds the CPU's byte-wide program memory from a framed pin-level byte stream.
//   Frame: LEN byte (N), N payload bytes written to addresses 0..N-1, then a CHK
//   byte that must equal the XOR of the payload. The CPU is held in reset for the
//   whole load and is released only once a frame has checked good.
//
//   State table
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LEN   | waiting for the length byte
//   DATA  | streaming payload bytes into program memory
//   CHK   | waiting for the checksum byte
//   RUN   | frame good, CPU released
//   ERROR | bad length or bad checksum, CPU held
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle load request (honoured in IDLE, RUN, ERROR)
//   in_valid    stream byte valid
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle (LEN, DATA, CHK)
//   pm_wr_en    program memory write enable, one cycle per payload byte
//   pm_addr     program memory write address
//   pm_wr_data  program memory write data
//   cpu_rst     active-high CPU reset hold, low only in RUN
//   load_done   high while in RUN
//   load_err    high while in ERROR

module program_loader #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wr_data,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err
);

    // One extra counter bit so a full-depth frame (N = 2**ADD_WIDTH) is
    // reachable without the counter wrapping.
    localparam int         CNT_W   = ADD_WIDTH + 1;
    localparam logic [8:0] MAX_LEN = 9'(1 << ADD_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHK   = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] chk_q;
    logic [8:0]            len_ext;
    logic                  len_ok;
    logic                  last_byte;
    logic                  xfer;

    // The length is judged at 9 bits so the upper bound holds for every
    // legal ADD_WIDTH, including 8 where no byte value exceeds the depth.
    assign len_ext   = 9'(in_data);
    assign len_ok    = (in_data != '0) && (len_ext <= MAX_LEN);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_byte = (cnt_inc == len_q);
    assign xfer      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cpu_rst   = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = len_ok ? DATA : ERROR;
            end
            DATA: begin
                in_ready = 1'b1;
                if (xfer && last_byte) state_nxt = CHK;
            end
            CHK: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = (in_data == chk_q) ? RUN : ERROR;
            end
            RUN: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
                if (start) state_nxt = LEN;
            end
            ERROR: begin
                load_err = 1'b1;
                if (start) state_nxt = LEN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Payload datapath. The write strobe defaults low every cycle so each
    // accepted payload byte produces exactly one write pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            chk_q      <= '0;
            pm_wr_en   <= 1'b0;
            pm_addr    <= '0;
            pm_wr_data <= '0;
        end else begin
            pm_wr_en <= 1'b0;
            if (state == LEN && xfer) begin
                len_q <= CNT_W'(in_data);
                cnt_q <= '0;
                chk_q <= '0;
            end
            if (state == DATA && xfer) begin
                pm_wr_en   <= 1'b1;
                pm_addr    <= cnt_q[ADD_WIDTH-1:0];
                pm_wr_data <= in_data;
                chk_q      <= chk_q ^ in_data;
                cnt_q      <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader (ADD_WIDTH = 7). A negedge monitor mirrors
//   program memory writes and counts stream transfers; the main sequence compares
//   outputs and the mirrored memory against hand-computed values.

module tb_program_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pm_wr_en;
    logic [6:0] pm_addr;
    logic [7:0] pm_wr_data;
    logic       cpu_rst;
    logic       load_done;
    logic       load_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] mem [128];
    int wr_count   = 0;
    int xfer_count = 0;
    int order_err  = 0;

    program_loader #(.ADD_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_addr    (pm_addr),
        .pm_wr_data (pm_wr_data),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+2, so negedge sees stable inputs and outputs.
    always @(negedge clk) begin
        if (rst) begin
            if (pm_wr_en) begin
                mem[pm_addr] = pm_wr_data;
                if (32'(pm_addr) != wr_count) order_err++;
                wr_count++;
            end
            if (in_valid && in_ready) xfer_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        budget = 50;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget--;
            if (budget == 0) begin
                check("xfer_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_pm_wr_en"},   32'(pm_wr_en),   32'd0);
        check({tag, "_pm_addr"},    32'(pm_addr),    32'd0);
        check({tag, "_pm_wr_data"}, 32'(pm_wr_data), 32'd0);
        check({tag, "_cpu_rst"},    32'(cpu_rst),    32'd1);
        check({tag, "_load_done"},  32'(load_done),  32'd0);
        check({tag, "_load_err"},   32'(load_err),   32'd0);
    endtask

    initial begin
        logic [7:0] exp_mem [128];
        logic [7:0] x;
        int         bad;

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // 1: reset values, then a good 3-byte frame
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        pulse_start();
        wr_count = 0;
        send_byte(8'd3, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA0, 0);
        send_byte(8'hB6, 0);
        check("t1_load_done", 32'(load_done), 32'd1);
        check("t1_cpu_rst",   32'(cpu_rst),   32'd0);
        check("t1_load_err",  32'(load_err),  32'd0);
        check("t1_in_ready",  32'(in_ready),  32'd0);
        check("t1_wr_count",  32'(wr_count),  32'd3);
        check("t1_mem0",      32'(mem[0]),    32'h13);
        check("t1_mem1",      32'(mem[1]),    32'h05);
        check("t1_mem2",      32'(mem[2]),    32'hA0);
        check("t1_order",     32'(order_err), 32'd0);

        // 2: start from RUN re-asserts cpu_rst next cycle; bad checksum; recovery
        pulse_start();
        check("t2_cpu_rst_after_start", 32'(cpu_rst),   32'd1);
        check("t2_done_cleared",        32'(load_done), 32'd0);
        send_byte(8'd3, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h00, 0);
        check("t2_load_err", 32'(load_err),  32'd1);
        check("t2_cpu_rst",  32'(cpu_rst),   32'd1);
        check("t2_done",     32'(load_done), 32'd0);
        pulse_start();
        check("t2_err_cleared", 32'(load_err), 32'd0);
        wr_count = 0;
        send_byte(8'd2, 0);
        send_byte(8'h5A, 1);
        send_byte(8'hC3, 0);
        send_byte(8'h99, 2);
        check("t2_recover_done", 32'(load_done), 32'd1);
        check("t2_recover_err",  32'(load_err),  32'd0);
        check("t2_mem0",         32'(mem[0]),    32'h5A);
        check("t2_mem1",         32'(mem[1]),    32'hC3);

        // 3: illegal lengths go straight to ERROR with no writes
        wr_count = 0;
        pulse_start();
        send_byte(8'd0, 0);
        check("t3_len0_err",   32'(load_err), 32'd1);
        check("t3_len0_ready", 32'(in_ready), 32'd0);
        pulse_start();
        send_byte(8'd129, 0);
        check("t3_len129_err", 32'(load_err), 32'd1);
        check("t3_no_writes",  32'(wr_count), 32'd0);

        // 4: full-depth frame with random gaps
        pulse_start();
        wr_count   = 0;
        xfer_count = 0;
        order_err  = 0;
        x = 8'h00;
        for (int i = 0; i < 128; i++) begin
            exp_mem[i] = 8'($urandom_range(0, 255));
            x = x ^ exp_mem[i];
        end
        send_byte(8'd128, 1);
        for (int i = 0; i < 128; i++) send_byte(exp_mem[i], int'($urandom_range(0, 2)));
        send_byte(x, 1);
        check("t4_done",      32'(load_done),  32'd1);
        check("t4_wr_count",  32'(wr_count),   32'd128);
        check("t4_wr_vs_xfer", 32'(xfer_count - 2), 32'(wr_count));
        check("t4_order",     32'(order_err),  32'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("t4_mem_mismatches", 32'(bad), 32'd0);
        check("t4_wr_en_idle", 32'(pm_wr_en), 32'd0);

        // 5: reset mid-frame, then a clean reload
        pulse_start();
        send_byte(8'd4, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_midreset");
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        wr_count = 0;
        send_byte(8'd4, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h44, 0);
        check("t5_done",     32'(load_done), 32'd1);
        check("t5_wr_count", 32'(wr_count),  32'd4);
        check("t5_mem3",     32'(mem[3]),    32'h44);
        check("t5_mem1",     32'(mem[1]),    32'h22);

        // 6: start ignored during DATA
        pulse_start();
        wr_count = 0;
        send_byte(8'd3, 0);
        start = 1'b1;
        send_byte(8'h01, 0);
        check("t6_ready_with_start", 32'(in_ready), 32'd1);
        tick();
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h04, 0);
        send_byte(8'h07, 0);
        check("t6_done",     32'(load_done), 32'd1);
        check("t6_wr_count", 32'(wr_count),  32'd3);
        check("t6_mem2",     32'(mem[2]),    32'h04);

        // 6: in IDLE, held in_valid is harmless and start with in_valid takes start only
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hE1;
        tick();
        in_data  = 8'h3C;
        tick();
        check("t6_idle_no_err",   32'(load_err), 32'd0);
        check("t6_idle_no_ready", 32'(in_ready), 32'd0);
        xfer_count = 0;
        in_data = 8'h02;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("t6_start_taken",   32'(in_ready),   32'd1);
        check("t6_byte_not_taken", 32'(xfer_count), 32'd0);
        wr_count = 0;
        send_byte(8'd1, 0);
        send_byte(8'h5C, 0);
        send_byte(8'h5C, 0);
        check("t6_idle_frame_done", 32'(load_done), 32'd1);
        check("t6_idle_frame_mem0", 32'(mem[0]),    32'h5C);
        pulse_start();
        check("t6_cpu_rst_back", 32'(cpu_rst), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
